// File: rtl/uart_rx.sv
// ---------------------------------------------------------------------------
// uart_rx : 8N1 serial receiver, LSB first.
//
// The rx pin is asynchronous and goes through a two-flop synchroniser. Every
// decision is made on the synchronised copy only. A start bit is confirmed at
// its centre. The 8 data bits and the stop bit are then sampled at their
// centres. Each good byte is handed to the system side on a valid/ack
// handshake.
//
// Parameters
//   CLK_HZ     system clock frequency in Hz
//   BAUD       line rate in bit/s (CLK_HZ/BAUD must be >= 4)
//
// Ports
//   clk        in   system clock, all logic on posedge
//   rstn       in   synchronous reset, active-low
//   rx         in   serial line, idle high, asynchronous to clk
//   data       out  last accepted byte (registered)
//   valid      out  data holds a byte that has not been acknowledged
//   ack        in   consumer has taken data (only looked at while valid=1)
//   frame_err  out  one-cycle pulse when the stop bit is sampled low
//   overrun    out  sticky; a byte completed while valid=1 and was dropped
//   busy       out  receiver is in any state other than IDLE
// ---------------------------------------------------------------------------
module uart_rx #(
    parameter int CLK_HZ = 100_000_000,
    parameter int BAUD   = 9600
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       rx,
    output logic [7:0] data,
    output logic       valid,
    input  logic       ack,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);

    localparam int DIV   = CLK_HZ / BAUD;
    localparam int HALF  = DIV / 2;
    localparam int CNT_W = $clog2(DIV);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(HALF - 1);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] START   = 3'd1;
    localparam logic [2:0] DATA    = 3'd2;
    localparam logic [2:0] STOP    = 3'd3;
    localparam logic [2:0] WAIT_HI = 3'd4;

    logic             rx_p0;
    logic             rx_p1;
    logic             rx_s;
    logic [2:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       bitc;
    logic [7:0]       shreg;

    // Synchroniser: rx -> rx_p0 -> rx_p1 (rx_s)
    assign rx_s = rx_p1;
    assign busy = (state != IDLE);

    always_ff @(posedge clk) begin
        if (!rstn) begin
            rx_p0     <= 1'b1;
            rx_p1     <= 1'b1;
            state     <= IDLE;
            cnt       <= '0;
            bitc      <= '0;
            shreg     <= '0;
            data      <= '0;
            valid     <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            rx_p0     <= rx;
            rx_p1     <= rx_p0;
            frame_err <= 1'b0;

            // Consumer handshake. A byte load in the STOP branch below is
            // written later, so it takes priority over this clear.
            if (valid && ack) begin
                valid   <= 1'b0;
                overrun <= 1'b0;
            end

            // Frame stage: start check, bit sampling, stop check
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (!rx_s) begin
                        state <= START;
                    end
                end

                START: begin
                    if (cnt == CNT_MID) begin
                        cnt  <= '0;
                        bitc <= '0;
                        // A line that is high again at mid start bit was a glitch.
                        state <= rx_s ? IDLE : DATA;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                DATA: begin
                    if (cnt == CNT_LAST) begin
                        cnt   <= '0;
                        shreg <= {rx_s, shreg[7:1]};
                        if (bitc == 3'd7) begin
                            state <= STOP;
                        end else begin
                            bitc <= bitc + 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                STOP: begin
                    if (cnt == CNT_LAST) begin
                        cnt <= '0;
                        if (rx_s) begin
                            state <= IDLE;
                            // An ack in this same cycle frees the holding
                            // register, so the new byte is loaded instead of
                            // being counted as an overrun.
                            if (!valid || ack) begin
                                data  <= shreg;
                                valid <= 1'b1;
                            end else begin
                                overrun <= 1'b1;
                            end
                        end else begin
                            frame_err <= 1'b1;
                            state     <= WAIT_HI;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                WAIT_HI: begin
                    // Holding off until the line is high again keeps a break
                    // or a stuck-low line from starting a new frame.
                    cnt <= '0;
                    if (rx_s) begin
                        state <= IDLE;
                    end
                end

                default: begin
                    cnt   <= '0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
module tb_uart_rx;

    localparam int CLK_HZ = 1_600_000;
    localparam int BAUD   = 100_000;
    localparam int DIV    = CLK_HZ / BAUD;   // 16
    localparam int HALF   = DIV / 2;         // 8
    localparam int LAT    = 2 + HALF + 9 * DIV + 1;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       rx = 1'b1;
    logic [7:0] data;
    logic       valid;
    logic       ack = 1'b0;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    int n_checks = 0;
    int n_fail   = 0;
    int fe_count = 0;

    uart_rx #(.CLK_HZ(CLK_HZ), .BAUD(BAUD)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .rx        (rx),
        .data      (data),
        .valid     (valid),
        .ack       (ack),
        .frame_err (frame_err),
        .overrun   (overrun),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Count clock cycles on which frame_err is high.
    always @(posedge clk) begin
        if (rstn && frame_err === 1'b1) fe_count++;
    end

    // Reference model of the consumer-visible state.
    logic [7:0] m_data;
    logic       m_valid;
    logic       m_overrun;

    task automatic send_bit(input logic v);
        rx = v;
        repeat (DIV) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit(stop_bit);
    endtask

    task automatic pulse_ack();
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
    endtask

    task automatic wait_valid(input int limit);
        for (int k = 0; k < limit && valid !== 1'b1; k++) @(negedge clk);
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        rx = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({data, valid, frame_err, overrun, busy} !== 12'h000) begin
            n_fail++;
            $display("FAIL reset_outputs: got data=%h v=%b fe=%b ov=%b busy=%b, expected all 0",
                     data, valid, frame_err, overrun, busy);
        end
        rstn = 1'b1;
        repeat (4) @(negedge clk);
        n_checks++;
        if (valid !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release: got v=%b busy=%b, expected 0 0", valid, busy);
        end
    endtask

    task automatic test_two_bytes();
        logic [7:0] exp_b [2];
        int fe0;
        exp_b[0] = 8'h55;
        exp_b[1] = 8'hA3;
        fe0 = fe_count;
        for (int i = 0; i < 2; i++) begin
            send_frame(exp_b[i], 1'b1);
            n_checks++;
            if (valid !== 1'b1 || data !== exp_b[i]) begin
                n_fail++;
                $display("FAIL two_bytes_rx%0d: got v=%b data=%h, expected v=1 data=%h",
                         i, valid, data, exp_b[i]);
            end
            pulse_ack();
            n_checks++;
            if (valid !== 1'b0 || overrun !== 1'b0) begin
                n_fail++;
                $display("FAIL two_bytes_ack%0d: got v=%b ov=%b, expected 0 0", i, valid, overrun);
            end
        end
        n_checks++;
        if (fe_count !== fe0) begin
            n_fail++;
            $display("FAIL two_bytes_fe: got %0d frame_err cycles, expected 0", fe_count - fe0);
        end
    endtask

    task automatic test_glitch();
        int fe0;
        fe0 = fe_count;
        rx = 1'b0;
        repeat (4) @(negedge clk);
        rx = 1'b1;
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL glitch_busy_high: got busy=%b, expected 1", busy);
        end
        repeat (2 * DIV) @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || valid !== 1'b0 || fe_count !== fe0) begin
            n_fail++;
            $display("FAIL glitch_reject: got busy=%b v=%b fe_cycles=%0d, expected 0 0 0",
                     busy, valid, fe_count - fe0);
        end
    endtask

    task automatic test_frame_error();
        int fe0;
        fe0 = fe_count;
        send_frame(8'h3C, 1'b0);
        rx = 1'b0;
        repeat (40) @(negedge clk);
        n_checks++;
        if (fe_count - fe0 !== 1 || valid !== 1'b0) begin
            n_fail++;
            $display("FAIL frame_err_pulse: got fe_cycles=%0d v=%b, expected 1 0",
                     fe_count - fe0, valid);
        end
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL frame_err_hold: got busy=%b while line low, expected 1", busy);
        end
        rx = 1'b1;
        repeat (5) @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || valid !== 1'b0 || fe_count - fe0 !== 1) begin
            n_fail++;
            $display("FAIL frame_err_release: got busy=%b v=%b fe_cycles=%0d, expected 0 0 1",
                     busy, valid, fe_count - fe0);
        end
    endtask

    task automatic test_overrun();
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        n_checks++;
        if (valid !== 1'b1 || data !== 8'h11 || overrun !== 1'b1) begin
            n_fail++;
            $display("FAIL overrun_set: got v=%b data=%h ov=%b, expected 1 11 1", valid, data, overrun);
        end
        pulse_ack();
        n_checks++;
        if (valid !== 1'b0 || overrun !== 1'b0 || data !== 8'h11) begin
            n_fail++;
            $display("FAIL overrun_clear: got v=%b ov=%b data=%h, expected 0 0 11", valid, overrun, data);
        end
    endtask

    task automatic test_reset_mid_frame();
        send_bit(1'b0);
        for (int i = 0; i < 3; i++) send_bit(1'b1);
        rstn = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || valid !== 1'b0 || data !== 8'h00) begin
            n_fail++;
            $display("FAIL midreset_state: got busy=%b v=%b data=%h, expected 0 0 00", busy, valid, data);
        end
        rstn = 1'b1;
        repeat (10 * DIV) @(negedge clk);
        n_checks++;
        if (valid !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_spurious: got v=%b busy=%b, expected 0 0", valid, busy);
        end
        send_frame(8'h0F, 1'b1);
        n_checks++;
        if (valid !== 1'b1 || data !== 8'h0F) begin
            n_fail++;
            $display("FAIL midreset_next: got v=%b data=%h, expected 1 0f", valid, data);
        end
        pulse_ack();
    endtask

    task automatic test_latency();
        int lat;
        logic [7:0] b;
        b = 8'($urandom);
        lat = 0;
        fork
            send_frame(b, 1'b1);
            begin
                @(negedge clk);
                lat = 1;
                while (valid !== 1'b1 && lat < 400) begin
                    @(negedge clk);
                    lat++;
                end
            end
        join
        n_checks++;
        if (lat < LAT - 1 || lat > LAT + 1 || data !== b) begin
            n_fail++;
            $display("FAIL latency: got %0d clks data=%h, expected %0d+/-1 data=%h", lat, data, LAT, b);
        end
        pulse_ack();
    endtask

    task automatic test_random();
        logic [7:0] b;
        m_valid   = 1'b0;
        m_overrun = 1'b0;
        m_data    = data;
        for (int i = 0; i < 10; i++) begin
            b = 8'($urandom);
            repeat ($urandom_range(0, 20)) @(negedge clk);
            send_frame(b, 1'b1);
            if (!m_valid) begin
                m_data  = b;
                m_valid = 1'b1;
            end else begin
                m_overrun = 1'b1;
            end
            n_checks++;
            if (valid !== m_valid || data !== m_data || overrun !== m_overrun) begin
                n_fail++;
                $display("FAIL random_frame%0d: got v=%b data=%h ov=%b, expected v=%b data=%h ov=%b",
                         i, valid, data, overrun, m_valid, m_data, m_overrun);
            end
            if ($urandom_range(0, 2) != 0) begin
                repeat ($urandom_range(0, 3)) @(negedge clk);
                pulse_ack();
                if (m_valid) begin
                    m_valid   = 1'b0;
                    m_overrun = 1'b0;
                end
                n_checks++;
                if (valid !== m_valid || overrun !== m_overrun) begin
                    n_fail++;
                    $display("FAIL random_ack%0d: got v=%b ov=%b, expected v=%b ov=%b",
                             i, valid, overrun, m_valid, m_overrun);
                end
            end
        end
        if (valid === 1'b1) pulse_ack();
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_b [3];
        int fe0;
        exp_b[0] = 8'h00;
        exp_b[1] = 8'hFF;
        exp_b[2] = 8'h81;
        fe0 = fe_count;
        fork
            for (int i = 0; i < 3; i++) send_frame(exp_b[i], 1'b1);
            for (int j = 0; j < 3; j++) begin
                wait_valid(12 * DIV);
                n_checks++;
                if (valid !== 1'b1 || data !== exp_b[j]) begin
                    n_fail++;
                    $display("FAIL b2b_rx%0d: got v=%b data=%h, expected v=1 data=%h",
                             j, valid, data, exp_b[j]);
                end
                repeat (2) @(negedge clk);
                pulse_ack();
            end
        join
        repeat (4) @(negedge clk);
        n_checks++;
        if (overrun !== 1'b0 || fe_count !== fe0 || valid !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_flags: got ov=%b fe_cycles=%0d v=%b, expected 0 0 0",
                     overrun, fe_count - fe0, valid);
        end
    endtask

    initial begin
        test_reset();
        test_two_bytes();
        test_glitch();
        test_frame_error();
        test_overrun();
        test_reset_mid_frame();
        test_latency();
        test_random();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
